// File: rtl/instr_issue_unit.sv
// Instruction issue unit: encodes loader fields into Stage 1 words, buffers them in a FIFO,
// and issues one word or a bubble per enabled cycle, stalling on RAW hazards.
// Latency: push at edge N into an empty FIFO issues at edge N+1 (no hazard, issue_en = 1).
// Backpressure: in_ready = rst && (count < DEPTH); full FIFO never accepts, even on a pop cycle.
// Ports: clk/rst (sync, active-low); in_* loader handshake and fields; issue_en freezes issue side;
//        InstrOut/InstrValid registered Stage 1 word; count occupancy; bubble_count saturating.
module instr_issue_unit #(
    parameter int DEPTH         = 4,
    parameter int HAZARD_WINDOW = 2
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic [5:0]                 in_opcode,
    input  logic [4:0]                 in_dst,
    input  logic [4:0]                 in_src1,
    input  logic [4:0]                 in_src2,
    input  logic                       issue_en,
    output logic [31:0]                InstrOut,
    output logic                       InstrValid,
    output logic [$clog2(DEPTH):0]     count,
    output logic [15:0]                bubble_count
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

    logic [31:0]   r_mem [DEPTH];
    logic [AW-1:0] r_wr_ptr;
    logic [AW-1:0] r_rd_ptr;
    logic [CW-1:0] r_count;
    logic [4:0]    r_hist [HAZARD_WINDOW];   // index 0 = most recent issue slot
    logic [31:0]   r_instr;
    logic          r_instr_vld;
    logic [15:0]   r_bubbles;

    logic [31:0]   w_word;
    logic [31:0]   w_head;
    logic          w_empty;
    logic          w_hazard;
    logic          w_push;
    logic          w_pop;
    logic          w_stall;

    assign w_word  = {in_opcode, in_dst, in_src1, in_src2, 11'd0};
    assign w_head  = r_mem[r_rd_ptr];
    assign w_empty = (r_count == '0);

    // Ready depends on count and rst only, so a pop never lets a push into a full FIFO.
    assign in_ready = rst && (r_count < DEPTH_C);
    assign w_push   = in_valid && in_ready;

    // Register 0 is hardwired and never creates a dependency.
    always_comb begin
        w_hazard = 1'b0;
        for (int i = 0; i < HAZARD_WINDOW; i++) begin
            if ((r_hist[i] != 5'd0) &&
                ((w_head[20:16] == r_hist[i]) || (w_head[15:11] == r_hist[i]))) begin
                w_hazard = 1'b1;
            end
        end
    end

    assign w_pop   = issue_en && !w_empty && !w_hazard;
    assign w_stall = issue_en && !w_empty && w_hazard;

    // Storage needs no reset: pointers define which entries are live.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= w_word;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_wr_ptr    <= '0;
            r_rd_ptr    <= '0;
            r_count     <= '0;
            r_instr     <= 32'd0;
            r_instr_vld <= 1'b0;
            r_bubbles   <= 16'd0;
            for (int i = 0; i < HAZARD_WINDOW; i++) begin
                r_hist[i] <= 5'd0;
            end
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + AW'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + AW'(1);
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + CW'(1);
                2'b01:   r_count <= r_count - CW'(1);
                default: r_count <= r_count;
            endcase

            if (issue_en) begin
                // Every enabled slot enters the history; bubbles record as r0.
                for (int i = 1; i < HAZARD_WINDOW; i++) begin
                    r_hist[i] <= r_hist[i-1];
                end
                r_hist[0] <= w_pop ? w_head[25:21] : 5'd0;
                r_instr     <= w_pop ? w_head : 32'd0;
                r_instr_vld <= w_pop;
                if (w_stall && (r_bubbles != 16'hFFFF)) begin
                    r_bubbles <= r_bubbles + 16'd1;
                end
            end
        end
    end

    assign InstrOut     = r_instr;
    assign InstrValid   = r_instr_vld;
    assign count        = r_count;
    assign bubble_count = r_bubbles;

endmodule

// File: tb/tb_instr_issue_unit.sv
// Testbench for instr_issue_unit: directed steps plus random traffic checked against a
// queue-based reference model of the issue rules.
module tb_instr_issue_unit;

    localparam int DEPTH = 4;
    localparam int W     = 2;

    logic        clk;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [5:0]  in_opcode;
    logic [4:0]  in_dst;
    logic [4:0]  in_src1;
    logic [4:0]  in_src2;
    logic        issue_en;
    logic [31:0] InstrOut;
    logic        InstrValid;
    logic [2:0]  count;
    logic [15:0] bubble_count;

    instr_issue_unit #(.DEPTH(DEPTH), .HAZARD_WINDOW(W)) dut (
        .clk          (clk),
        .rst          (rst),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .in_opcode    (in_opcode),
        .in_dst       (in_dst),
        .in_src1      (in_src1),
        .in_src2      (in_src2),
        .issue_en     (issue_en),
        .InstrOut     (InstrOut),
        .InstrValid   (InstrValid),
        .count        (count),
        .bubble_count (bubble_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model: pending words in order, and dst of the most recent issue slots.
    logic [31:0] m_q[$];
    logic [4:0]  m_slots[$];
    logic [31:0] m_out;
    logic        m_vld;
    logic [15:0] m_bub;

    function automatic logic [31:0] enc(input logic [5:0] op, input logic [4:0] d, s1, s2);
        return {op, d, s1, s2, 11'd0};
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_q.delete();
        m_slots.delete();
        for (int i = 0; i < W; i++) m_slots.push_back(5'd0);
        m_out = 32'd0;
        m_vld = 1'b0;
        m_bub = 16'd0;
    endtask

    task automatic check_all(input string tag);
        chk({tag, ".out"},   InstrOut, m_out);
        chk({tag, ".vld"},   {31'd0, InstrValid}, {31'd0, m_vld});
        chk({tag, ".count"}, {29'd0, count}, m_q.size());
        chk({tag, ".bub"},   {16'd0, bubble_count}, {16'd0, m_bub});
        chk({tag, ".rdy"},   {31'd0, in_ready},
            {31'd0, (rst && (m_q.size() < DEPTH))});
    endtask

    // One clock: drive inputs, advance the model at the edge, check #1 after it.
    task automatic step(input string tag, input logic r, v, en,
                        input logic [5:0] op, input logic [4:0] d, s1, s2);
        logic        acc;
        logic        haz;
        logic [31:0] head;
        rst = r; in_valid = v; issue_en = en;
        in_opcode = op; in_dst = d; in_src1 = s1; in_src2 = s2;
        acc = r && v && (m_q.size() < DEPTH);
        @(posedge clk);
        if (!r) begin
            model_reset();
        end else begin
            if (en) begin
                if (m_q.size() > 0) begin
                    head = m_q[0];
                    haz = 1'b0;
                    foreach (m_slots[i])
                        if (m_slots[i] != 5'd0 &&
                            (m_slots[i] == head[20:16] || m_slots[i] == head[15:11]))
                            haz = 1'b1;
                    if (!haz) begin
                        m_out = head; m_vld = 1'b1;
                        void'(m_q.pop_front());
                        m_slots.push_front(head[25:21]);
                    end else begin
                        m_out = 32'd0; m_vld = 1'b0;
                        m_slots.push_front(5'd0);
                        if (m_bub != 16'hFFFF) m_bub = m_bub + 16'd1;
                    end
                end else begin
                    m_out = 32'd0; m_vld = 1'b0;
                    m_slots.push_front(5'd0);
                end
                void'(m_slots.pop_back());
            end
            if (acc) m_q.push_back(enc(op, d, s1, s2));
        end
        #1;
        check_all(tag);
    endtask

    task automatic idle(input string tag, input logic en);
        step(tag, 1'b1, 1'b0, en, 6'd0, 5'd0, 5'd0, 5'd0);
    endtask

    initial begin
        logic [15:0] bub0;
        model_reset();
        rst = 1'b0; in_valid = 1'b0; issue_en = 1'b0;
        in_opcode = '0; in_dst = '0; in_src1 = '0; in_src2 = '0;

        // Reset state, and in_ready held low while reset is asserted.
        step("rst0", 1'b0, 1'b1, 1'b1, 6'd1, 5'd1, 5'd1, 5'd1);
        step("rst1", 1'b0, 1'b1, 1'b1, 6'd1, 5'd1, 5'd1, 5'd1);
        chk("rst.out", InstrOut, 32'd0);
        chk("rst.rdy", {31'd0, in_ready}, 32'd0);

        // Single word: visible one edge after the push.
        step("t1.push", 1'b1, 1'b1, 1'b1, 6'd1, 5'd3, 5'd1, 5'd2);
        idle("t1.iss", 1'b1);
        chk("t1.word", InstrOut, 32'h04611000);
        chk("t1.vld", {31'd0, InstrValid}, 32'd1);

        // Dependent pair back to back: exactly W bubbles.
        idle("t2.fl0", 1'b1);
        idle("t2.fl1", 1'b1);
        step("t2.pa", 1'b1, 1'b1, 1'b1, 6'd1, 5'd3, 5'd1, 5'd2);
        step("t2.pb", 1'b1, 1'b1, 1'b1, 6'd1, 5'd4, 5'd3, 5'd0);
        chk("t2.a", InstrOut, 32'h04611000);
        idle("t2.b1", 1'b1);
        chk("t2.b1v", {31'd0, InstrValid}, 32'd0);
        idle("t2.b2", 1'b1);
        chk("t2.b2v", {31'd0, InstrValid}, 32'd0);
        idle("t2.c", 1'b1);
        chk("t2.word", InstrOut, 32'h04830000);
        chk("t2.bub", {16'd0, bubble_count}, 32'd2);

        // Producer writing r0, consumer reading r0: no bubble.
        bub0 = bubble_count;
        step("t3.p", 1'b1, 1'b1, 1'b1, 6'd2, 5'd0, 5'd5, 5'd6);
        step("t3.c", 1'b1, 1'b1, 1'b1, 6'd3, 5'd7, 5'd0, 5'd0);
        idle("t3.i0", 1'b1);
        chk("t3.vld", {31'd0, InstrValid}, 32'd1);
        idle("t3.i1", 1'b1);
        chk("t3.bub", {16'd0, bubble_count}, {16'd0, bub0});

        // Frozen issue side: fill, fifth word held off, then drain in order.
        for (int k = 1; k <= 5; k++)
            step("t4.push", 1'b1, 1'b1, 1'b0, 6'(k), 5'(10 + k), 5'd0, 5'd0);
        chk("t4.count", {29'd0, count}, 32'd4);
        chk("t4.rdy", {31'd0, in_ready}, 32'd0);
        idle("t4.pop1", 1'b1);
        chk("t4.first", InstrOut, enc(6'd1, 5'd11, 5'd0, 5'd0));
        chk("t4.rdy1", {31'd0, in_ready}, 32'd1);
        for (int k = 0; k < 3; k++) idle("t4.drain", 1'b1);
        chk("t4.last", InstrOut, enc(6'd4, 5'd14, 5'd0, 5'd0));

        // Reset mid-stream drops everything pending.
        for (int k = 0; k < 3; k++)
            step("t5.fill", 1'b1, 1'b1, 1'b0, 6'd9, 5'(20 + k), 5'd0, 5'd0);
        step("t5.rst", 1'b0, 1'b0, 1'b1, 6'd0, 5'd0, 5'd0, 5'd0);
        chk("t5.count", {29'd0, count}, 32'd0);
        for (int k = 0; k < 3; k++) begin
            idle("t5.after", 1'b1);
            chk("t5.vld", {31'd0, InstrValid}, 32'd0);
        end

        // Sustained push+pop across pointer wrap.
        for (int k = 0; k < 10; k++) begin
            step("t6.stream", 1'b1, 1'b1, 1'b1, 6'($urandom_range(63)),
                 5'(1 + k), 5'd0, 5'd0);
            if (k > 0) chk("t6.count", {29'd0, count}, 32'd1);
        end
        idle("t6.tail", 1'b1);

        // Random traffic with frequent register overlap.
        for (int k = 0; k < 400; k++) begin
            step("rnd", ($urandom_range(99) >= 2), ($urandom_range(99) < 70),
                 ($urandom_range(99) < 75), 6'($urandom_range(63)),
                 5'($urandom_range(7)), 5'($urandom_range(7)), 5'($urandom_range(7)));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
